// File: rtl/iommu_pdtw.sv
// rtl/iommu_pdtw.sv - process-directory-table walker: resolves (device_id, process_id) to a process context
// Walks PD20/PD17/PD8 non-leaf levels, then reads the {ta, fsc} leaf pair and writes it to the PDTC.
package iommu_pkg;
   typedef struct packed {
      logic [63:0] ta;
      logic [63:0] fsc;
   } pc_t;
endpackage

module iommu_pdtw #(
   parameter int unsigned DEVICE_ID_WIDTH  = 24,
   parameter int unsigned PROCESS_ID_WIDTH = 20,
   parameter int unsigned PLEN             = 56
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        req_valid_i,
   output logic                        req_ready_o,
   input  logic [DEVICE_ID_WIDTH-1:0]  req_did_i,
   input  logic [PROCESS_ID_WIDTH-1:0] req_pid_i,
   input  logic [3:0]                  req_pdtp_mode_i,
   input  logic [43:0]                 req_pdtp_ppn_i,
   input  logic                        flush_i,
   output logic                        mem_req_o,
   input  logic                        mem_gnt_i,
   output logic [PLEN-1:0]             mem_addr_o,
   input  logic                        mem_rvalid_i,
   input  logic [63:0]                 mem_rdata_i,
   input  logic                        mem_err_i,
   output logic                        update_o,
   output logic [DEVICE_ID_WIDTH-1:0]  up_did_o,
   output logic [PROCESS_ID_WIDTH-1:0] up_pid_o,
   output iommu_pkg::pc_t              up_content_o,
   output logic                        done_o,
   output logic                        error_o,
   output logic [11:0]                 cause_o,
   output logic                        busy_o
);

   localparam logic [11:0] CAUSE_ACCESS  = 12'd265;
   localparam logic [11:0] CAUSE_INVALID = 12'd266;
   localparam logic [11:0] CAUSE_MISCONF = 12'd267;

   typedef enum logic [2:0] {
      IDLE, NL_REQ, NL_WAIT, TA_REQ, TA_WAIT, FSC_REQ, FSC_WAIT, DONE
   } state_e;

   state_e                      state_q, state_d;
   logic [DEVICE_ID_WIDTH-1:0]  did_q;
   logic [PROCESS_ID_WIDTH-1:0] pid_q;
   logic [43:0]                 ppn_q;
   logic [1:0]                  lvl_q;
   logic [63:0]                 ta_q, fsc_q;
   logic                        err_q, discard_q;
   logic [11:0]                 cause_q;

   logic                        mode_ok, pid_ok;
   logic [4:0]                  pid_w;
   logic [1:0]                  lvl_init;
   logic                        accept, fault, ld_nl, ld_ta, ld_fsc;
   logic [11:0]                 fault_cause;
   logic [19:0]                 pid20;
   logic [8:0]                  pdi;
   logic [PLEN-1:0]             base, nl_addr, ta_addr, fsc_addr;

   // lvl_init counts non-leaf levels still to walk; PD8 goes straight to the leaf
   always_comb begin
      mode_ok  = 1'b1;
      pid_w    = 5'd20;
      lvl_init = 2'd2;
      unique case (req_pdtp_mode_i)
         4'd1:    begin pid_w = 5'd8;  lvl_init = 2'd0; end
         4'd2:    begin pid_w = 5'd17; lvl_init = 2'd1; end
         4'd3:    begin pid_w = 5'd20; lvl_init = 2'd2; end
         default: mode_ok = 1'b0;
      endcase
      pid_ok = ((req_pid_i >> pid_w) == '0);
   end

   always_comb begin
      pid20 = 20'(pid_q);
      unique case (lvl_q)
         2'd2:    pdi = {6'b0, pid20[19:17]};
         2'd1:    pdi = pid20[16:8];
         default: pdi = {1'b0, pid20[7:0]};
      endcase
      base     = PLEN'({ppn_q, 12'h000});
      nl_addr  = base + PLEN'({pdi, 3'b000});
      ta_addr  = base + PLEN'({pid20[7:0], 4'h0});
      fsc_addr = ta_addr + PLEN'(8);
   end

   always_comb begin
      state_d     = state_q;
      accept      = 1'b0;
      fault       = 1'b0;
      fault_cause = cause_q;
      ld_nl       = 1'b0;
      ld_ta       = 1'b0;
      ld_fsc      = 1'b0;
      unique case (state_q)
         IDLE: if (req_valid_i) begin
            accept = 1'b1;
            if (!mode_ok || !pid_ok) begin
               fault       = 1'b1;
               fault_cause = CAUSE_INVALID;
               state_d     = DONE;
            end else begin
               state_d = (lvl_init == 2'd0) ? TA_REQ : NL_REQ;
            end
         end
         NL_REQ:  if (mem_gnt_i) state_d = NL_WAIT;
         NL_WAIT: if (mem_rvalid_i) begin
            state_d = DONE;
            fault   = 1'b1;
            if (mem_err_i)                  fault_cause = CAUSE_ACCESS;
            else if (!mem_rdata_i[0])       fault_cause = CAUSE_INVALID;
            else if (mem_rdata_i[9:1] != '0 || mem_rdata_i[63:54] != '0)
                                            fault_cause = CAUSE_MISCONF;
            else begin
               fault   = 1'b0;
               ld_nl   = 1'b1;
               state_d = (lvl_q == 2'd1) ? TA_REQ : NL_REQ;
            end
         end
         TA_REQ:  if (mem_gnt_i) state_d = TA_WAIT;
         TA_WAIT: if (mem_rvalid_i) begin
            state_d = DONE;
            fault   = 1'b1;
            if (mem_err_i)            fault_cause = CAUSE_ACCESS;
            else if (!mem_rdata_i[0]) fault_cause = CAUSE_INVALID;
            else begin
               fault   = 1'b0;
               ld_ta   = 1'b1;
               state_d = FSC_REQ;
            end
         end
         FSC_REQ:  if (mem_gnt_i) state_d = FSC_WAIT;
         FSC_WAIT: if (mem_rvalid_i) begin
            state_d = DONE;
            if (mem_err_i) begin
               fault       = 1'b1;
               fault_cause = CAUSE_ACCESS;
            end else begin
               ld_fsc = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         did_q     <= '0;
         pid_q     <= '0;
         ppn_q     <= '0;
         lvl_q     <= '0;
         ta_q      <= '0;
         fsc_q     <= '0;
         err_q     <= 1'b0;
         discard_q <= 1'b0;
         cause_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            did_q <= req_did_i;
            pid_q <= req_pid_i;
            ppn_q <= req_pdtp_ppn_i;
            lvl_q <= lvl_init;
            err_q <= 1'b0;
         end
         if (fault) begin
            err_q   <= 1'b1;
            cause_q <= fault_cause;
         end
         if (ld_nl) begin
            ppn_q <= mem_rdata_i[53:10];
            lvl_q <= lvl_q - 2'd1;
         end
         if (ld_ta)  ta_q  <= mem_rdata_i;
         if (ld_fsc) fsc_q <= mem_rdata_i;
         // an invalidation racing the walk makes its result stale, so it is never cached
         if (state_q == IDLE)  discard_q <= 1'b0;
         else if (flush_i)     discard_q <= 1'b1;
      end
   end

   always_comb begin
      unique case (state_q)
         NL_REQ:  mem_addr_o = nl_addr;
         TA_REQ:  mem_addr_o = ta_addr;
         FSC_REQ: mem_addr_o = fsc_addr;
         default: mem_addr_o = '0;
      endcase
   end

   assign req_ready_o      = (state_q == IDLE);
   assign busy_o           = (state_q != IDLE);
   assign mem_req_o        = (state_q == NL_REQ) || (state_q == TA_REQ) || (state_q == FSC_REQ);
   assign done_o           = (state_q == DONE);
   assign error_o          = done_o && err_q;
   assign update_o         = done_o && !err_q && !discard_q;
   assign cause_o          = cause_q;
   assign up_did_o         = did_q;
   assign up_pid_o         = pid_q;
   assign up_content_o.ta  = ta_q;
   assign up_content_o.fsc = fsc_q;

endmodule
